aes_round_ctrl: RTL and testbench

//   Round sequencer for the AES-128 encryption datapath. It waits for the SPI front end to finish

---
 rtl/aes_ctrl_pkg.sv | 21 ++
 rtl/aes_rcon_gen.sv | 24 ++
 rtl/aes_round_ctrl.sv | 121 ++++++++++++
 tb/tb_aes_round_ctrl.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_ctrl_pkg.sv
// Shared types and helpers for the AES-128 round controller.
package aes_ctrl_pkg;

  typedef enum logic [3:0] {
    ST_IDLE  = 4'd0,
    ST_LOAD  = 4'd1,
    ST_INIT  = 4'd2,
    ST_SUB   = 4'd3,
    ST_ROUND = 4'd4,
    ST_DONE  = 4'd5
  } ctrl_state_t;

  localparam int         AES128_NR = 10;
  localparam logic [7:0] RCON_INIT = 8'h01;

  // Multiply by x in GF(2^8) modulo the AES polynomial.
  function automatic logic [7:0] xtime(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
  endfunction

endpackage

// File: rtl/aes_rcon_gen.sv
// Round-constant register for the AES-128 key expansion: restarts at 01, advances by xtime.
module aes_rcon_gen
  import aes_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       clear,
  input  logic       step,
  output logic [7:0] rcon
);

  logic [7:0] rcon_q;

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      rcon_q <= RCON_INIT;
    end else if (step) begin
      rcon_q <= xtime(rcon_q);
    end
  end

  assign rcon = rcon_q;

endmodule

// File: rtl/aes_round_ctrl.sv
// AES-128 round sequencer: waits for the key/plaintext load to finish, then steps the datapath
// through the initial AddRoundKey, NR rounds and completion.
module aes_round_ctrl
  import aes_ctrl_pkg::*;
#(
  parameter int NR       = AES128_NR,
  parameter int SBOX_LAT = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       load,
  output logic       state_en,
  output logic       key_en,
  output logic       sel_init,
  output logic       mix_en,
  output logic [3:0] round,
  output logic [7:0] rcon,
  output logic       done,
  output logic [3:0] debug_state
);

  localparam logic [3:0] ROUND_LAST = 4'(NR);
  localparam logic [1:0] WAIT_LAST  = (SBOX_LAT > 0) ? 2'(SBOX_LAT - 1) : 2'd0;
  localparam ctrl_state_t AFTER_KEY = (SBOX_LAT == 0) ? ST_ROUND : ST_SUB;

  ctrl_state_t state_q, state_d;
  logic [3:0]  round_q, round_d;
  logic [1:0]  wait_q, wait_d;
  logic        load_q;
  logic        rcon_clear, rcon_step;
  logic        state_en_q, key_en_q, sel_init_q, mix_en_q, done_q;

  // NOTE: every always_comb output gets a default first, so no path leaves a latch behind.
  always_comb begin
    state_d    = state_q;
    round_d    = round_q;
    wait_d     = wait_q;
    rcon_clear = 1'b0;
    rcon_step  = 1'b0;

    case (state_q)
      ST_IDLE: if (load) state_d = ST_LOAD;
      ST_LOAD: if (!load && load_q) state_d = ST_INIT;
      ST_INIT: begin
        round_d = 4'd1;
        wait_d  = 2'd0;
        state_d = AFTER_KEY;
      end
      ST_SUB: begin
        if (wait_q == WAIT_LAST) state_d = ST_ROUND;
        else                     wait_d  = wait_q + 2'd1;
      end
      ST_ROUND: begin
        if (round_q == ROUND_LAST) begin
          state_d = ST_DONE;
        end else begin
          round_d   = round_q + 4'd1;
          rcon_step = 1'b1;
          wait_d    = 2'd0;
          state_d   = AFTER_KEY;
        end
      end
      ST_DONE: if (load) state_d = ST_LOAD;
      default: state_d = ST_IDLE;
    endcase

    // A new load while the rounds are running abandons the encryption.
    if (load && (state_q inside {ST_INIT, ST_SUB, ST_ROUND})) begin
      state_d   = ST_LOAD;
      rcon_step = 1'b0;
    end

    if (state_d == ST_LOAD) begin
      round_d    = 4'd0;
      rcon_clear = 1'b1;
    end
  end

  // Outputs are decoded from the next state and registered, so they track state_q glitch-free.
  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      round_q    <= 4'd0;
      wait_q     <= 2'd0;
      load_q     <= 1'b0;
      state_en_q <= 1'b0;
      key_en_q   <= 1'b0;
      sel_init_q <= 1'b0;
      mix_en_q   <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      round_q    <= round_d;
      wait_q     <= wait_d;
      load_q     <= load;
      state_en_q <= (state_d == ST_INIT) || (state_d == ST_ROUND);
      key_en_q   <= (state_d == ST_INIT) || (state_d == ST_ROUND);
      sel_init_q <= (state_d == ST_INIT);
      mix_en_q   <= (state_d == ST_ROUND) && (round_d != ROUND_LAST);
      done_q     <= (state_d == ST_DONE);
    end
  end

  aes_rcon_gen u_rcon_gen (
    .clk   (clk),
    .reset (reset),
    .clear (rcon_clear),
    .step  (rcon_step),
    .rcon  (rcon)
  );

  assign state_en    = state_en_q;
  assign key_en      = key_en_q;
  assign sel_init    = sel_init_q;
  assign mix_en      = mix_en_q;
  assign done        = done_q;
  assign round       = round_q;
  assign debug_state = state_q;

endmodule

// File: tb/tb_aes_round_ctrl.sv
// Directed bench for aes_round_ctrl: three builds (SBOX_LAT 0/1/2) share stimulus; the default
// build also drives a behavioural AES-128 datapath checked against the FIPS-197 C.1 vector.
module tb_aes_round_ctrl;

  localparam logic [127:0] KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [7:0] RCON_EXP [10] =
    '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};

  logic clk = 1'b0;
  logic reset, load;
  logic       se [3], ke [3], si [3], mx [3], dn [3];
  logic [3:0] rd [3], ds [3];
  logic [7:0] rc [3];

  int vectors = 0;
  int errors  = 0;

  always #5 clk = ~clk;

  // Index into the arrays equals the build's SBOX_LAT.
  aes_round_ctrl #(.SBOX_LAT(0)) u_dut_l0 (
    .clk(clk), .reset(reset), .load(load), .state_en(se[0]), .key_en(ke[0]), .sel_init(si[0]),
    .mix_en(mx[0]), .round(rd[0]), .rcon(rc[0]), .done(dn[0]), .debug_state(ds[0]));
  aes_round_ctrl #(.SBOX_LAT(1)) u_dut (
    .clk(clk), .reset(reset), .load(load), .state_en(se[1]), .key_en(ke[1]), .sel_init(si[1]),
    .mix_en(mx[1]), .round(rd[1]), .rcon(rc[1]), .done(dn[1]), .debug_state(ds[1]));
  aes_round_ctrl #(.SBOX_LAT(2)) u_dut_l2 (
    .clk(clk), .reset(reset), .load(load), .state_en(se[2]), .key_en(ke[2]), .sel_init(si[2]),
    .mix_en(mx[2]), .round(rd[2]), .rcon(rc[2]), .done(dn[2]), .debug_state(ds[2]));

  // ---------------- behavioural AES-128 datapath ----------------
  function automatic logic [7:0] gmul2(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
    logic [7:0] a = a_in, b = b_in, p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      a = gmul2(a);
      b = b >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
    logic [15:0] t = {x, x};
    return t[15-n -: 8];
  endfunction

  // S-box from first principles: x^254 inverse followed by the affine map.
  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] inv = 8'h01;
    for (int i = 7; i >= 0; i--) begin
      inv = gmul(inv, inv);
      if (i != 0) inv = gmul(inv, x);
    end
    return inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
  endfunction

  function automatic logic [127:0] next_key(input logic [127:0] k, input logic [7:0] rcon_v);
    logic [31:0] w3 = k[31:0];
    logic [31:0] t, n0, n1, n2, n3;
    t  = {sbox(w3[23:16]), sbox(w3[15:8]), sbox(w3[7:0]), sbox(w3[31:24])} ^ {rcon_v, 24'h0};
    n0 = k[127:96] ^ t;
    n1 = k[95:64]  ^ n0;
    n2 = k[63:32]  ^ n1;
    n3 = k[31:0]   ^ n2;
    return {n0, n1, n2, n3};
  endfunction

  function automatic logic [127:0] round_fn(input logic [127:0] s, input logic [127:0] k,
                                            input logic mix);
    logic [7:0] a [16];
    logic [7:0] o [16];
    logic [127:0] r;
    for (int c = 0; c < 4; c++)
      for (int w = 0; w < 4; w++)
        a[c*4+w] = sbox(s[127-8*(((c+w)%4)*4+w) -: 8]);
    for (int c = 0; c < 4; c++) begin
      if (mix) begin
        o[c*4+0] = gmul2(a[c*4]) ^ gmul(a[c*4+1], 8'h03) ^ a[c*4+2] ^ a[c*4+3];
        o[c*4+1] = a[c*4] ^ gmul2(a[c*4+1]) ^ gmul(a[c*4+2], 8'h03) ^ a[c*4+3];
        o[c*4+2] = a[c*4] ^ a[c*4+1] ^ gmul2(a[c*4+2]) ^ gmul(a[c*4+3], 8'h03);
        o[c*4+3] = gmul(a[c*4], 8'h03) ^ a[c*4+1] ^ a[c*4+2] ^ gmul2(a[c*4+3]);
      end else begin
        for (int w = 0; w < 4; w++) o[c*4+w] = a[c*4+w];
      end
    end
    for (int i = 0; i < 16; i++) r[127-8*i -: 8] = o[i];
    return r ^ k;
  endfunction

  logic [127:0] dp_state, dp_key;

  always @(posedge clk) begin
    if (se[1]) dp_state <= si[1] ? (PT ^ KEY) : round_fn(dp_state, next_key(dp_key, rc[1]), mx[1]);
    if (ke[1]) dp_key   <= si[1] ? KEY : next_key(dp_key, rc[1]);
  end

  // ---------------- stimulus helpers ----------------
  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check_reset_values(input string tag);
    for (int d = 0; d < 3; d++) begin
      vectors++;
      if ({se[d], ke[d], si[d], mx[d], dn[d], rd[d], ds[d], rc[d]} !== {5'b0, 4'd0, 4'd0, 8'h01}) begin
        errors++;
        $display("FAIL %s lat%0d: got en/ke/si/mx/dn=%b%b%b%b%b round=%h state=%h rcon=%h, want 00000 0 0 01",
                 tag, d, se[d], ke[d], si[d], mx[d], dn[d], rd[d], ds[d], rc[d]);
      end
    end
  endtask

  // Caller has just dropped load; INIT must follow one edge later, then the rounds run out.
  task automatic run_check(input string tag);
    cyc(1);
    for (int d = 0; d < 3; d++) begin
      vectors++;
      if ({se[d], ke[d], si[d], mx[d], dn[d], ds[d]} !== {5'b11100, 4'd2}) begin
        errors++;
        $display("FAIL %s init lat%0d: got en/ke/si/mx/dn=%b%b%b%b%b state=%h, want 11100 2",
                 tag, d, se[d], ke[d], si[d], mx[d], dn[d], ds[d]);
      end
    end
    for (int t = 1; t <= 35; t++) begin
      cyc(1);
      for (int d = 0; d < 3; d++) begin
        int per = d + 1;
        int k = t / per;
        logic pulse = (t % per == 0) && (k <= 10);
        logic fin = (t >= 1 + 10 * per);
        logic [3:0] e_rd = fin ? 4'd10 : (pulse ? 4'(k) : 4'(k + 1));
        logic [3:0] e_ds = fin ? 4'd5 : (pulse ? 4'd4 : 4'd3);
        logic [12:0] exp_v = {pulse, pulse, 1'b0, pulse && (k != 10), fin, e_rd, e_ds};
        logic [12:0] got_v = {se[d], ke[d], si[d], mx[d], dn[d], rd[d], ds[d]};
        vectors++;
        if (got_v !== exp_v) begin
          errors++;
          $display("FAIL %s seq lat%0d t=%0d: got en/ke/si/mx/dn=%b round=%0d state=%0d, want %b round=%0d state=%0d",
                   tag, d, t, got_v[12:8], got_v[7:4], got_v[3:0], exp_v[12:8], e_rd, e_ds);
        end
        if (pulse) begin
          vectors++;
          if (rc[d] !== RCON_EXP[k-1]) begin
            errors++;
            $display("FAIL %s rcon lat%0d round %0d: got %h want %h", tag, d, k, rc[d], RCON_EXP[k-1]);
          end
        end
      end
    end
    vectors++;
    if (dp_state !== CT) begin
      errors++;
      $display("FAIL %s cyphertext: got %h want %h", tag, dp_state, CT);
    end
    cyc(5);
    vectors++;
    if ({dn[0], dn[1], dn[2]} !== 3'b111) begin
      errors++;
      $display("FAIL %s done hold: got %b want 111", tag, {dn[0], dn[1], dn[2]});
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset;
    reset = 1'b1;
    load  = 1'b1;
    cyc(2);
    check_reset_values("reset");
    load  = 1'b0;
    reset = 1'b0;
    cyc(3);
    vectors++;
    if (ds[1] !== 4'd0) begin
      errors++;
      $display("FAIL reset idle_with_load_low: got state %0d want 0", ds[1]);
    end
  endtask

  task automatic test_encrypt;
    load = 1'b1;
    cyc(300);
    vectors++;
    if (ds[1] !== 4'd1 || se[1] !== 1'b0) begin
      errors++;
      $display("FAIL encrypt load_state: got state %0d en %b want 1 0", ds[1], se[1]);
    end
    load = 1'b0;
    run_check("encrypt");
  endtask

  task automatic test_abort;
    load = 1'b1;
    cyc(1);
    vectors++;
    if (ds[1] !== 4'd1 || dn[1] !== 1'b0) begin
      errors++;
      $display("FAIL abort done_drop: got state %0d done %b want 1 0", ds[1], dn[1]);
    end
    cyc(3);
    load = 1'b0;
    cyc(1);
    cyc(10);
    vectors++;
    if (ds[1] !== 4'd4 || rd[1] !== 4'd5) begin
      errors++;
      $display("FAIL abort reach_round5: got state %0d round %0d want 4 5", ds[1], rd[1]);
    end
    load = 1'b1;
    cyc(1);
    for (int d = 0; d < 3; d++) begin
      vectors++;
      if ({se[d], ke[d], si[d], mx[d], dn[d], rd[d], ds[d], rc[d]} !== {5'b0, 4'd0, 4'd1, 8'h01}) begin
        errors++;
        $display("FAIL abort lat%0d: got en/ke/si/mx/dn=%b%b%b%b%b round=%0d state=%0d rcon=%h, want 00000 0 1 01",
                 d, se[d], ke[d], si[d], mx[d], dn[d], rd[d], ds[d], rc[d]);
      end
    end
    for (int i = 0; i < 3; i++) begin
      cyc(1);
      vectors++;
      if (se[1] !== 1'b0 || ke[1] !== 1'b0 || dn[1] !== 1'b0) begin
        errors++;
        $display("FAIL abort quiet cycle %0d: got en %b key %b done %b want 0 0 0", i, se[1], ke[1], dn[1]);
      end
    end
    load = 1'b0;
    run_check("fresh");
  endtask

  task automatic test_reset_mid_run;
    load = 1'b1;
    cyc(1);
    load = 1'b0;
    cyc(1);
    cyc(14);
    vectors++;
    if (ds[1] !== 4'd4 || rd[1] !== 4'd7) begin
      errors++;
      $display("FAIL midreset reach_round7: got state %0d round %0d want 4 7", ds[1], rd[1]);
    end
    reset = 1'b1;
    cyc(1);
    check_reset_values("midreset");
    reset = 1'b0;
    cyc(20);
    for (int d = 0; d < 3; d++) begin
      vectors++;
      if (ds[d] !== 4'd0 || dn[d] !== 1'b0) begin
        errors++;
        $display("FAIL midreset stay_idle lat%0d: got state %0d done %b want 0 0", d, ds[d], dn[d]);
      end
    end
  endtask

  task automatic test_single_pulse;
    load = 1'b1;
    cyc(1);
    load = 1'b0;
    run_check("pulse");
  endtask

  initial begin
    test_reset();
    test_encrypt();
    test_abort();
    test_reset_mid_run();
    test_single_pulse();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
